perf_counter_ctrl: RTL and testbench

Memory-mapped controller that schedules a bank of performance-counter slots over a shared set of event sources (cache hit/miss, branch predict, pipeline stall lines). The CPU configures each slot through a memory-mapped register window: event select, run-length threshold and continuous mode. The CPU reads and clears counts through the same window, using the LC-3b mem_read/mem_write/mem_resp handshake. The block sits on the data-memory bus beside the arbiter and responds only to its own address window.

---
 rtl/perf_counter_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_perf_counter_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl
//   Bank of performance-counter slots behind a small memory-mapped register
//   window on the LC-3b data bus. Each slot selects one event line and counts
//   runs of that event that reach a programmable length. Counts saturate at
//   0xFFFF, and an overflow sets a sticky STATUS bit that can drive irq.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   events          raw event lines, sampled on posedge clk
//   mem_address     bus byte address (word registers, bit 0 ignored)
//   mem_read        read request, held until mem_resp
//   mem_write       write request, held until mem_resp (wins over mem_read)
//   mem_wdata       write data
//   mem_byte_enable per-byte write enable
//   mem_rdata       read data, valid while mem_resp=1
//   mem_resp        one-cycle completion pulse
//   hit             address inside the window with a request pending
//   irq             any sticky overflow set while CTRL.irq_en=1
//
// Register map (byte offsets from BASE_ADDR)
//   0x00 CTRL    [0] enable [1] freeze [2] clear (pulse, reads 0) [3] irq_en
//   0x02 STATUS  [NUM_SLOTS-1:0] sticky overflow, write-1-to-clear
//   0x04+4i CFG_i   [2:0] event_sel [6:3] thresh [7] cont [8] slot_en
//   0x06+4i COUNT_i 16-bit count
`timescale 1ns/1ps
module perf_counter_ctrl #(
    parameter int          NUM_EVENTS = 8,
    parameter int          NUM_SLOTS  = 4,
    parameter logic [15:0] BASE_ADDR  = 16'hFF00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [15:0]           mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [15:0]           mem_wdata,
    input  logic [1:0]            mem_byte_enable,
    output logic [15:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  hit,
    output logic                  irq
);
    // Window is the register span rounded up to a power of two; offsets in the
    // padding decode to nothing, read 0 and still complete the handshake.
    localparam int WIN_BITS = $clog2(4 + 4 * NUM_SLOTS);
    localparam int IDX_W    = WIN_BITS - 1;

    typedef enum logic [1:0] {IDLE, RESP, DROP} bus_state_t;
    bus_state_t state_reg;

    logic [IDX_W-1:0]     idx;
    logic                 wr_fire;
    logic                 ctrl_we;
    logic                 status_we;
    logic                 clear_pulse;
    logic [15:0]          be_mask;
    logic [15:0]          rd_value;
    logic                 enable_reg;
    logic                 freeze_reg;
    logic                 irq_en_reg;
    logic [NUM_SLOTS-1:0] status;
    logic [NUM_SLOTS-1:0] status_w1c;
    logic [NUM_SLOTS-1:0] cfg_we;
    logic [NUM_SLOTS-1:0] count_we;
    logic [8:0]           cfg_q   [NUM_SLOTS];
    logic [15:0]          count_q [NUM_SLOTS];
    logic                 unused_addr_bit;

    assign idx             = mem_address[WIN_BITS-1:1];
    assign unused_addr_bit = mem_address[0];
    assign hit = (mem_address[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]) && (mem_read || mem_write);

    // A write takes effect only on the accepting IDLE edge, so held strobes
    // during RESP/DROP never write twice.
    assign wr_fire     = (state_reg == IDLE) && hit && mem_write;
    assign be_mask     = {{8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};
    assign ctrl_we     = wr_fire && (idx == '0);
    assign status_we   = wr_fire && (idx == IDX_W'(1));
    assign clear_pulse = ctrl_we && mem_byte_enable[0] && mem_wdata[2];
    assign status_w1c  = status_we ? (mem_wdata[NUM_SLOTS-1:0] & be_mask[NUM_SLOTS-1:0]) : '0;
    assign irq         = irq_en_reg && (|status);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_reg <= 1'b0;
            freeze_reg <= 1'b0;
            irq_en_reg <= 1'b0;
        end else if (ctrl_we && mem_byte_enable[0]) begin
            enable_reg <= mem_wdata[0];
            freeze_reg <= mem_wdata[1];
            irq_en_reg <= mem_wdata[3];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [8:0]  cfg_reg;
            logic [15:0] count_reg;
            logic [3:0]  run_len_reg;
            logic        fired_reg;
            logic        ovf_reg;
            logic        ev;
            logic        active;
            logic        at_thresh;
            logic        inc_req;
            logic        saturated;
            logic [15:0] count_wr;
            logic [8:0]  cfg_wr;

            assign cfg_we[gi]   = wr_fire && (idx == IDX_W'(2 + 2 * gi));
            assign count_we[gi] = wr_fire && (idx == IDX_W'(3 + 2 * gi));

            assign ev        = events[cfg_reg[2:0]];
            assign active    = enable_reg && !freeze_reg && cfg_reg[8];
            assign at_thresh = (run_len_reg == cfg_reg[6:3]);
            // Once the run reaches thresh it parks there; fired suppresses
            // further counts in one-shot mode until the event drops.
            assign inc_req   = active && ev && at_thresh && (!fired_reg || cfg_reg[7]);
            assign saturated = (count_reg == 16'hFFFF);
            assign count_wr  = (count_reg & ~be_mask) | (mem_wdata & be_mask);
            assign cfg_wr    = (cfg_reg & ~be_mask[8:0]) | (mem_wdata[8:0] & be_mask[8:0]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cfg_reg     <= '0;
                    count_reg   <= '0;
                    run_len_reg <= '0;
                    fired_reg   <= 1'b0;
                    ovf_reg     <= 1'b0;
                end else if (clear_pulse) begin
                    count_reg   <= '0;
                    run_len_reg <= '0;
                    fired_reg   <= 1'b0;
                    ovf_reg     <= 1'b0;
                end else begin
                    if (cfg_we[gi]) begin
                        cfg_reg <= cfg_wr;
                    end
                    // A CPU write to the count drops a coincident increment.
                    if (count_we[gi]) begin
                        count_reg <= count_wr;
                    end else if (inc_req && !saturated) begin
                        count_reg <= count_reg + 16'd1;
                    end
                    // New overflow beats a same-cycle write-1-to-clear.
                    if (inc_req && saturated && !count_we[gi]) begin
                        ovf_reg <= 1'b1;
                    end else if (status_w1c[gi]) begin
                        ovf_reg <= 1'b0;
                    end
                    // Freeze/disable/reconfigure restarts run detection.
                    if (cfg_we[gi] || !active || !ev) begin
                        run_len_reg <= '0;
                        fired_reg   <= 1'b0;
                    end else if (!at_thresh) begin
                        run_len_reg <= run_len_reg + 4'd1;
                    end else begin
                        fired_reg <= 1'b1;
                    end
                end
            end

            assign cfg_q[gi]   = cfg_reg;
            assign count_q[gi] = count_reg;
            assign status[gi]  = ovf_reg;
        end
    endgenerate

    always_comb begin
        rd_value = '0;
        if (idx == '0) begin
            rd_value = {12'b0, irq_en_reg, 1'b0, freeze_reg, enable_reg};
        end else if (idx == IDX_W'(1)) begin
            rd_value[NUM_SLOTS-1:0] = status;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == IDX_W'(2 + 2 * i)) begin
                rd_value = {7'b0, cfg_q[i]};
            end
            if (idx == IDX_W'(3 + 2 * i)) begin
                rd_value = count_q[i];
            end
        end
    end

    // Read data is captured on the accepting edge, i.e. the pre-write value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        mem_rdata <= rd_value;
                        mem_resp  <= 1'b1;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    mem_resp  <= 1'b0;
                    state_reg <= DROP;
                end
                DROP: begin
                    if (!mem_read && !mem_write) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    mem_resp  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Scoreboard bench for perf_counter_ctrl: each bus transaction pushes its
// expected read data; a negedge monitor pops and compares on mem_resp.
`timescale 1ns/1ps
module tb_perf_counter_ctrl;
    logic        clk;
    logic        reset;
    logic [7:0]  events;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        hit;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       tag_q[$];
    logic [15:0] exp_q[$];
    bit          chk_q[$];
    bit          drop_ev = 1'b0;
    string       mon_tag;
    logic [15:0] mon_exp;
    bit          mon_chk;

    perf_counter_ctrl #(
        .NUM_EVENTS(8),
        .NUM_SLOTS (4),
        .BASE_ADDR (16'hFF00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .events         (events),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .hit            (hit),
        .irq            (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: counts produced by one isolated run of len high cycles.
    function automatic int run_hits(input int len, input int thresh, input bit cont);
        if (len <= thresh) return 0;
        return cont ? (len - thresh) : 1;
    endfunction

    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_value("resp_unexpected", 32'(mem_resp), 32'd0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                mon_chk = chk_q.pop_front();
                $display("[TB] %s rdata=0x%04h", mon_tag, mem_rdata);
                if (mon_chk) check_value(mon_tag, 32'(mem_rdata), 32'(mon_exp));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input bit is_wr, input logic [15:0] addr, input logic [15:0] data,
                            input logic [1:0] be, input logic [15:0] exp, input string tag,
                            input int hold);
        int cyc;
        int extra;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        chk_q.push_back(!is_wr);
        mem_address     = addr;
        mem_wdata       = data;
        mem_byte_enable = be;
        mem_write       = is_wr;
        mem_read        = !is_wr;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (mem_resp !== 1'b1 && cyc < 8);
        check_value({tag, "_lat"}, 32'(cyc), 32'd1);
        if (drop_ev) begin
            events  = '0;
            drop_ev = 1'b0;
        end
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (mem_resp === 1'b1) extra++;
        end
        if (hold > 0) check_value({tag, "_no_double"}, 32'(extra), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        idle(2);
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        bus_xfer(1'b0, addr, 16'h0000, 2'b11, exp, tag, 0);
    endtask

    task automatic bus_write_be(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
        bus_xfer(1'b1, addr, data, be, 16'h0000, $sformatf("wr_%04h", addr), 0);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus_write_be(addr, data, 2'b11);
    endtask

    task automatic burst(input int sel, input int len);
        events[sel] = 1'b1;
        idle(len);
        events[sel] = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot;
        int nresp;
        logic [15:0] exp_cnt;
        logic        exp_ovf;

        reset           = 1'b1;
        events          = '0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        idle(2);
        check_value("rst_resp",  32'(mem_resp),  32'd0);
        check_value("rst_rdata", 32'(mem_rdata), 32'd0);
        check_value("rst_irq",   32'(irq),       32'd0);
        reset = 1'b0;
        idle(1);

        // Reset values and handshake
        bus_read(16'hFF00, 16'h0000, "ctrl_rst");
        bus_read(16'hFF02, 16'h0000, "status_rst");
        bus_read(16'hFF04, 16'h0000, "cfg0_rst");
        bus_read(16'hFF06, 16'h0000, "count0_rst");
        bus_xfer(1'b0, 16'hFF00, 16'h0000, 2'b11, 16'h0000, "ctrl_hold", 3);

        // One-shot runs, thresh=2
        bus_write(16'hFF04, 16'h0112);
        bus_write(16'hFF00, 16'h0001);
        burst(2, 6);
        burst(2, 6);
        bus_read(16'hFF06, 16'(2 * run_hits(6, 2, 0)), "count0_oneshot");

        // Continuous runs, thresh=2
        bus_write(16'hFF04, 16'h0192);
        bus_write(16'hFF06, 16'h0000);
        burst(2, 6);
        burst(2, 6);
        bus_read(16'hFF06, 16'(2 * run_hits(6, 2, 1)), "count0_cont");

        // thresh=0 one-shot: once per run
        bus_write(16'hFF04, 16'h0102);
        bus_write(16'hFF06, 16'h0000);
        burst(2, 5);
        burst(2, 1);
        burst(2, 3);
        bus_read(16'hFF06, 16'(run_hits(5, 0, 0) + run_hits(1, 0, 0) + run_hits(3, 0, 0)), "count0_t0");
        bus_read(16'hFF04, 16'h0102, "cfg0_rb");

        // Saturation and overflow interrupt on slot 1
        bus_write(16'hFF0A, 16'hFFFE);
        bus_write(16'hFF08, 16'h0185);
        bus_write(16'hFF00, 16'h0009);
        burst(5, 4);
        tot     = 'hFFFE + run_hits(4, 0, 1);
        exp_cnt = (tot > 'hFFFF) ? 16'hFFFF : 16'(tot);
        exp_ovf = (tot > 'hFFFF);
        bus_read(16'hFF0A, exp_cnt, "count1_sat");
        bus_read(16'hFF02, {15'b0, exp_ovf} << 1, "status_ovf");
        check_value("irq_set", 32'(irq), 32'(exp_ovf));
        bus_write(16'hFF02, 16'h0002);
        check_value("irq_clr", 32'(irq), 32'd0);
        bus_read(16'hFF02, 16'h0000, "status_w1c");

        // Byte-enable writes
        bus_write_be(16'hFF0A, 16'h1234, 2'b01);
        bus_read(16'hFF0A, 16'hFF34, "count1_be_lo");
        bus_write_be(16'hFF0A, 16'hAB00, 2'b10);
        bus_read(16'hFF0A, 16'hAB34, "count1_be_hi");

        // COUNT write collides with a continuous increment
        bus_write(16'hFF04, 16'h0182);
        bus_write(16'hFF06, 16'h0000);
        events[2] = 1'b1;
        idle(3);
        drop_ev = 1'b1;
        bus_write(16'hFF06, 16'h0010);
        bus_read(16'hFF06, 16'h0010, "count0_wr_wins");

        // Freeze mid-run, thresh=3 one-shot: 3 post-unfreeze cycles miss, 4 hit
        bus_write(16'hFF04, 16'h011A);
        bus_write(16'hFF06, 16'h0000);
        events[2] = 1'b1;
        idle(2);
        bus_write(16'hFF00, 16'h000B);
        idle(3);
        bus_write(16'hFF00, 16'h0009);
        idle(1);
        events[2] = 1'b0;
        idle(1);
        bus_read(16'hFF06, 16'(run_hits(3, 3, 0)), "count0_frz3");
        events[2] = 1'b1;
        idle(2);
        bus_write(16'hFF00, 16'h000B);
        idle(3);
        bus_write(16'hFF00, 16'h0009);
        idle(2);
        events[2] = 1'b0;
        idle(1);
        bus_read(16'hFF06, 16'(run_hits(4, 3, 0)), "count0_frz4");

        // Global clear
        bus_write(16'hFF0A, 16'hFFFF);
        burst(5, 2);
        bus_read(16'hFF02, 16'h0002, "status_pre_clr");
        check_value("irq_pre_clr", 32'(irq), 32'd1);
        bus_write(16'hFF00, 16'h0005);
        bus_read(16'hFF00, 16'h0001, "ctrl_post_clr");
        bus_read(16'hFF02, 16'h0000, "status_post_clr");
        bus_read(16'hFF06, 16'h0000, "count0_post_clr");
        bus_read(16'hFF0A, 16'h0000, "count1_post_clr");
        check_value("irq_post_clr", 32'(irq), 32'd0);

        // Unmapped offset inside the window
        bus_read(16'hFF14, 16'h0000, "unmapped_rd");
        bus_write(16'hFF14, 16'hFFFF);
        bus_read(16'hFF14, 16'h0000, "unmapped_rd2");

        // Address just past the window is ignored
        mem_address = 16'hFF20;
        mem_read    = 1'b1;
        #1;
        check_value("oow_hit", 32'(hit), 32'd0);
        nresp = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_resp === 1'b1) nresp++;
        end
        check_value("oow_resp", 32'(nresp), 32'd0);
        mem_read = 1'b0;
        idle(1);

        // Reset while mem_resp is high
        mem_address = 16'hFF00;
        mem_read    = 1'b1;
        #1;
        check_value("win_hit", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        check_value("resp_pre_rst", 32'(mem_resp), 32'd1);
        reset = 1'b1;
        #1;
        check_value("resp_in_rst",  32'(mem_resp),  32'd0);
        check_value("rdata_in_rst", 32'(mem_rdata), 32'd0);
        mem_read = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);
        bus_read(16'hFF00, 16'h0000, "ctrl_after_rst");

        idle(2);
        check_value("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
